toggle_cover_detect: RTL and testbench
======================================

// Module: toggle_cover_detect
// PURPOSE
//  Toggle-event detector feeding the GEN_w<N>_toggle DPI coverage sinks.
//  - Samples a WIDTH-bit monitored signal every cycle and detects rise/fall transitions per bit.
//  - Optionally filters to first-hit-only events.
//  - Drives a 2*WIDTH valid vector (36 bits at defaults), one pulse per cover point.
//  - Keeps covered-point and event statistics for the harness.
// PARAMETERS
//  WIDTH           18  monitored signal width; valid width = 2*WIDTH
//  FIRST_HIT_ONLY  1   1: each cover point pulses once until clear; 0: every toggle pulses
//  EVT_CNT_W       16  width of saturating toggle-event counter
// PORTS
//  clock        in   1               single clock, rising edge
//  reset        in   1               synchronous, active-high
//  sig          in   WIDTH           monitored signal
//  en           in   1               1: report toggles; 0: track sig silently
//  clear        in   1               1-cycle pulse: clear covered mask and counters
//  valid        out  2*WIDTH         valid[2i]=rise of sig[i], valid[2i+1]=fall of sig[i]
//  covered_cnt  out  $clog2(2*WIDTH+1)  number of distinct points covered since reset/clear
//  evt_cnt      out  EVT_CNT_W       saturating count of cycles with any valid bit set
//  all_covered  out  1               all 2*WIDTH points covered
// BEHAVIOUR
//  - Reset (sync, high) values:
//    - valid=0, covered_cnt=0, evt_cnt=0, all_covered=0.
//    - prev=0, mask=0, state=UNPRIMED.
//  - FSM:
//    - UNPRIMED: captures sig into prev; emits nothing; goes to ACTIVE next cycle.
//      The first sample after reset never counts as a toggle.
//    - ACTIVE: rise = sig & ~prev, fall = ~sig & prev; prev <= sig every cycle.
//      Goes to DONE when mask becomes all-ones and FIRST_HIT_ONLY=1.
//    - DONE: valid held 0; prev still tracks sig; returns to ACTIVE on clear.
//  - Latency and events:
//    - valid is registered: a sig change sampled at edge k appears on valid after edge k.
//    - Pulse width is exactly 1 cycle; downstream samples it at edge k+1.
//    - raw[2i]=rise[i], raw[2i+1]=fall[i].
//    - evt = raw & {2*WIDTH{en}} & (FIRST_HIT_ONLY ? ~mask : '1).
//    - valid <= evt; mask <= mask | evt.
//  - Counters:
//    - covered_cnt <= popcount(mask | evt) (registered, same edge as valid).
//    - all_covered = (covered_cnt == 2*WIDTH).
//    - evt_cnt increments by 1 when |evt; saturates at all-ones, never wraps.
//  - Rules and boundary cases:
//    - en=0: prev still updates, so a toggle seen under en=0 is never reported later.
//      No mask or counter change.
//    - clear: mask=0, covered_cnt=0, evt_cnt=0, valid=0 that cycle; prev updates normally.
//      clear wins over any simultaneous toggle; that toggle is dropped, not deferred.
//    - clear in UNPRIMED is ignored; the state is already clean.
//    - Multi-bit toggles in one cycle: all corresponding valid bits set in the same cycle.
//    - FIRST_HIT_ONLY=0: mask and covered_cnt still track; state never enters DONE.
//    - Reset mid-operation: all state returns to reset values next edge.
//      The in-flight valid pulse is cancelled.
// STRUCTURE
//  - toggle_cover_pkg:
//    - localparam functions rise_idx(i)=2*i and fall_idx(i)=2*i+1.
//    - typedef enum {UNPRIMED, ACTIVE, DONE} tcd_state_e.
//    - function cnt_w(n)=$clog2(n+1).
//  - One sub-module: toggle_cover_popcount, a parameterised combinational popcount
//    over 2*WIDTH bits feeding the covered_cnt register.
//  - Top: prev reg, mask reg, FSM, valid reg, evt_cnt saturating counter.
// TESTING
//  1. reset, sig=18'h3FFFF held -> valid stays 0 (no false toggle from the reset prev=0);
//     covered_cnt=0.
//  2. sig 18'h00000 -> 18'h00001 -> valid=36'h1 for exactly one cycle, one cycle later;
//     covered_cnt=1; evt_cnt=1.
//  3. sig bit17 1->0 -> valid=36'h8_0000_0000 (bit35) single pulse.
//  4. FIRST_HIT_ONLY=1, toggle bit0 0->1->0->1 -> valid pulses 36'h1 then 36'h2, third edge silent;
//     covered_cnt=2.
//  5. sig 0 -> 18'h3FFFF -> 0 -> valid 36'h5_5555_5555 then 36'hA_AAAA_AAAA;
//     covered_cnt=36; all_covered=1; further toggles silent.
//  6. clear asserted in the same cycle sig goes 0->18'h1 -> valid=0; covered_cnt=0; evt_cnt=0;
//     next 1->0 gives valid=36'h2.
//  Also check: en=0 toggle then en=1 with steady sig -> no pulse.
//  Also check: evt_cnt saturation at EVT_CNT_W=4 -> holds at 15.

Source files
------------

// File: rtl/toggle_cover_pkg.sv
// Shared types and index helpers for the toggle coverage detector.
package toggle_cover_pkg;

  typedef enum logic [1:0] {UNPRIMED, ACTIVE, DONE} tcd_state_e;

  function automatic int rise_idx(input int i);
    return 2 * i;
  endfunction

  function automatic int fall_idx(input int i);
    return 2 * i + 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/toggle_cover_popcount.sv
// Combinational population count over N bits, result wide enough to hold N.
module toggle_cover_popcount
  import toggle_cover_pkg::*;
#(
  parameter int N = 36
) (
  input  logic [N-1:0]          bits,
  output logic [cnt_w(N)-1:0]   count
);

  localparam int CW = cnt_w(N);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/toggle_cover_detect.sv
// Per-bit rise/fall toggle detector driving one registered valid pulse per cover point,
// with optional first-hit filtering, covered-point count and saturating event count.
module toggle_cover_detect
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH          = 18,
  parameter bit FIRST_HIT_ONLY = 1'b1,
  parameter int EVT_CNT_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              sig,
  input  logic                          en,
  input  logic                          clear,
  output logic [2*WIDTH-1:0]            valid,
  output logic [cnt_w(2*WIDTH)-1:0]     covered_cnt,
  output logic [EVT_CNT_W-1:0]          evt_cnt,
  output logic                          all_covered
);

  localparam int NPTS = 2 * WIDTH;
  localparam int CW   = cnt_w(NPTS);

  tcd_state_e        state, state_nxt;
  logic [WIDTH-1:0]  prev;
  logic [NPTS-1:0]   mask, mask_nxt, raw, evt, hit_filter;
  logic              report, clear_eff;
  logic [CW-1:0]     pop;

  always_comb begin
    raw = '0;
    for (int i = 0; i < WIDTH; i++) begin
      raw[rise_idx(i)] = sig[i] & ~prev[i];
      raw[fall_idx(i)] = ~sig[i] & prev[i];
    end
  end

  // clear drops any toggle seen in the same cycle; it has no effect before priming
  always_comb begin
    report     = (state == ACTIVE) && !clear;
    clear_eff  = (state != UNPRIMED) && clear;
    hit_filter = FIRST_HIT_ONLY ? ~mask : {NPTS{1'b1}};
    evt        = report ? (raw & {NPTS{en}} & hit_filter) : '0;
    mask_nxt   = clear_eff ? '0 : (mask | evt);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UNPRIMED: state_nxt = ACTIVE;
      ACTIVE:   if (FIRST_HIT_ONLY && (&mask_nxt)) state_nxt = DONE;
      DONE:     if (clear) state_nxt = ACTIVE;
      default:  state_nxt = UNPRIMED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= UNPRIMED;
    else       state <= state_nxt;
  end

  toggle_cover_popcount #(.N(NPTS)) u_popcount (
    .bits  (mask_nxt),
    .count (pop)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      prev        <= '0;
      mask        <= '0;
      valid       <= '0;
      covered_cnt <= '0;
      evt_cnt     <= '0;
    end else begin
      prev        <= sig;
      mask        <= mask_nxt;
      valid       <= evt;
      covered_cnt <= pop;
      if (clear_eff)
        evt_cnt <= '0;
      else if ((|evt) && !(&evt_cnt))
        evt_cnt <= evt_cnt + EVT_CNT_W'(1);
    end
  end

  assign all_covered = (covered_cnt == CW'(NPTS));

endmodule

// File: tb/tb_toggle_cover_detect.sv
// Directed bench: default-parameter detector plus an every-toggle, 4-bit-counter instance on shared stimulus.
module tb_toggle_cover_detect;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] sig;
  logic        en;
  logic        clear;

  logic [35:0] valid,  valid2;
  logic [5:0]  covered_cnt, covered_cnt2;
  logic [15:0] evt_cnt;
  logic [3:0]  evt_cnt2;
  logic        all_covered, all_covered2;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  toggle_cover_detect dut (
    .clock       (clock),
    .reset       (reset),
    .sig         (sig),
    .en          (en),
    .clear       (clear),
    .valid       (valid),
    .covered_cnt (covered_cnt),
    .evt_cnt     (evt_cnt),
    .all_covered (all_covered)
  );

  toggle_cover_detect #(.WIDTH(18), .FIRST_HIT_ONLY(1'b0), .EVT_CNT_W(4)) dut_sat (
    .clock       (clock),
    .reset       (reset),
    .sig         (sig),
    .en          (en),
    .clear       (clear),
    .valid       (valid2),
    .covered_cnt (covered_cnt2),
    .evt_cnt     (evt_cnt2),
    .all_covered (all_covered2)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; sig = 18'h3FFFF; en = 1'b1; clear = 1'b0;
    step();
    chk("reset_valid",   64'(valid),       64'h0);
    chk("reset_cov",     64'(covered_cnt), 64'h0);
    chk("reset_evt",     64'(evt_cnt),     64'h0);
    chk("reset_allcov",  64'(all_covered), 64'h0);

    // 1: sig held high out of reset must not look like a rise
    reset = 1'b0;
    step();
    chk("t1_prime_valid", 64'(valid), 64'h0);
    step();
    chk("t1_active_valid", 64'(valid), 64'h0);
    chk("t1_cov",          64'(covered_cnt), 64'h0);

    // 2: single rise of bit0
    reset = 1'b1; sig = 18'h00000;
    step();
    reset = 1'b0;
    step();
    step();
    sig = 18'h00001;
    step();
    chk("t2_valid", 64'(valid),       64'h1);
    chk("t2_cov",   64'(covered_cnt), 64'h1);
    chk("t2_evt",   64'(evt_cnt),     64'h1);
    step();
    chk("t2_pulse_width", 64'(valid), 64'h0);

    // 3: bit17 rises then falls
    sig = 18'h20001;
    step();
    chk("t3_rise17", 64'(valid), 64'h4_0000_0000);
    sig = 18'h00001;
    step();
    chk("t3_fall17", 64'(valid),       64'h8_0000_0000);
    chk("t3_cov",    64'(covered_cnt), 64'h3);
    chk("t3_evt",    64'(evt_cnt),     64'h3);
    step();
    chk("t3_pulse_width", 64'(valid), 64'h0);

    // reset together with a toggle cancels the pulse
    sig = 18'h00000; reset = 1'b1;
    step();
    chk("midreset_valid", 64'(valid),       64'h0);
    chk("midreset_cov",   64'(covered_cnt), 64'h0);
    chk("midreset_evt",   64'(evt_cnt),     64'h0);

    // 4: first-hit filtering on bit0
    reset = 1'b0;
    step();
    step();
    sig = 18'h00001;
    step();
    chk("t4_rise", 64'(valid), 64'h1);
    sig = 18'h00000;
    step();
    chk("t4_fall", 64'(valid), 64'h2);
    sig = 18'h00001;
    step();
    chk("t4_silent", 64'(valid),       64'h0);
    chk("t4_cov",    64'(covered_cnt), 64'h2);
    chk("t4_evt",    64'(evt_cnt),     64'h2);

    // 5: clear, then all bits rise then fall
    sig = 18'h00000; clear = 1'b1;
    step();
    chk("t5_clear_cov", 64'(covered_cnt), 64'h0);
    chk("t5_clear_evt", 64'(evt_cnt),     64'h0);
    clear = 1'b0; sig = 18'h3FFFF;
    step();
    chk("t5_rise_all", 64'(valid),       64'h5_5555_5555);
    chk("t5_cov_half", 64'(covered_cnt), 64'd18);
    sig = 18'h00000;
    step();
    chk("t5_fall_all", 64'(valid),       64'hA_AAAA_AAAA);
    chk("t5_cov_full", 64'(covered_cnt), 64'd36);
    chk("t5_allcov",   64'(all_covered), 64'h1);
    chk("t5_evt",      64'(evt_cnt),     64'h2);
    sig = 18'h3FFFF;
    step();
    chk("t5_done_silent", 64'(valid), 64'h0);
    sig = 18'h00000;
    step();
    chk("t5_done_silent2", 64'(valid),       64'h0);
    chk("t5_done_cov",     64'(covered_cnt), 64'd36);

    // 6: clear wins over a simultaneous toggle
    clear = 1'b1; sig = 18'h00001;
    step();
    chk("t6_valid",  64'(valid),       64'h0);
    chk("t6_cov",    64'(covered_cnt), 64'h0);
    chk("t6_evt",    64'(evt_cnt),     64'h0);
    chk("t6_allcov", 64'(all_covered), 64'h0);
    clear = 1'b0; sig = 18'h00000;
    step();
    chk("t6_next_fall", 64'(valid),       64'h2);
    chk("t6_next_cov",  64'(covered_cnt), 64'h1);

    // toggle under en=0 is absorbed and never reported
    en = 1'b0; sig = 18'h00002;
    step();
    chk("en0_valid", 64'(valid), 64'h0);
    en = 1'b1;
    step();
    chk("en1_steady_valid", 64'(valid),       64'h0);
    chk("en1_steady_cov",   64'(covered_cnt), 64'h1);
    chk("en1_steady_evt",   64'(evt_cnt),     64'h1);

    // saturation of the 4-bit counter on the every-toggle instance
    clear = 1'b1;
    step();
    chk("sat_clear", 64'(evt_cnt2), 64'h0);
    clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sig = (i % 2 == 0) ? 18'h00003 : 18'h00002;
      step();
    end
    chk("sat_evt",       64'(evt_cnt2),     64'd15);
    chk("sat_valid",     64'(valid2),       64'h2);
    chk("sat_cov",       64'(covered_cnt2), 64'h2);
    chk("fho_evt",       64'(evt_cnt),      64'h2);
    chk("fho_last",      64'(valid),        64'h0);
    sig = 18'h00003;
    step();
    chk("sat_hold", 64'(evt_cnt2), 64'd15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
